// File: rtl/vram_arbiter.sv
// Video SRAM arbiter: screen fetch, memory initializer and CPU share one async SRAM.
// Optional one-entry CPU write-post buffer enabled by defining VRAM_WRITE_POST_EN.
module vram_arbiter #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic        clk28,
  input  logic        rst,
  input  logic        scr_req,
  input  logic [18:0] scr_addr,
  output logic        scr_ack,
  output logic [7:0]  scr_data,
  input  logic        init_req,
  input  logic [18:0] init_addr,
  input  logic [7:0]  init_wdata,
  output logic        init_ack,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [18:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic [18:0] va,
  input  logic [7:0]  vd_in,
  output logic [7:0]  vd_out,
  output logic        vd_oe,
  output logic        n_vrd,
  output logic        n_vwr,
  output logic        busy
);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;
`ifdef VRAM_WRITE_POST_EN
  typedef enum logic [1:0] {G_SCR, G_INIT, G_CPU, G_DRAIN} grant_t;
`else
  typedef enum logic [1:0] {G_SCR, G_INIT, G_CPU} grant_t;
`endif

  localparam logic [2:0] LAST_CNT = 3'(ACCESS_CYCLES - 1);

  state_t      r_state, w_nextState;
  grant_t      r_grant, w_grant;
  logic [2:0]  r_cnt;
  logic [18:0] r_addr, w_addr;
  logic [7:0]  r_wdata, w_wdata;
  logic        r_wr, w_wr;
  logic        w_start, w_lastCycle;
  logic        r_scrAck, r_initAck, r_cpuAck;
  logic [7:0]  r_scrData, r_cpuRdata;
  logic        w_scrReq, w_initReq, w_cpuReq;
`ifdef VRAM_WRITE_POST_EN
  logic        r_postValid, w_post;
  logic [18:0] r_postAddr;
  logic [7:0]  r_postData;
`endif

  // A requester still sees its req high during its ack cycle, so mask it there.
  assign w_scrReq    = scr_req  & ~r_scrAck;
  assign w_initReq   = init_req & ~r_initAck;
  assign w_cpuReq    = cpu_req  & ~r_cpuAck;
  assign w_lastCycle = (r_state == S_ACCESS) && (r_cnt == LAST_CNT);

  always_ff @(posedge clk28) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_start     = 1'b0;
    w_grant     = r_grant;
    w_addr      = r_addr;
    w_wdata     = r_wdata;
    w_wr        = r_wr;
`ifdef VRAM_WRITE_POST_EN
    w_post      = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_scrReq) begin
          w_start = 1'b1;
          w_grant = G_SCR;
          w_addr  = scr_addr;
          w_wr    = 1'b0;
        end else if (w_initReq) begin
          w_start = 1'b1;
          w_grant = G_INIT;
          w_addr  = init_addr;
          w_wdata = init_wdata;
          w_wr    = 1'b1;
        end
`ifdef VRAM_WRITE_POST_EN
        // A full buffer drains at CPU priority and holds off every CPU request.
        else if (r_postValid) begin
          w_start = 1'b1;
          w_grant = G_DRAIN;
          w_addr  = r_postAddr;
          w_wdata = r_postData;
          w_wr    = 1'b1;
        end else if (w_cpuReq && cpu_wr) begin
          w_post = 1'b1;
        end
`endif
        else if (w_cpuReq) begin
          w_start = 1'b1;
          w_grant = G_CPU;
          w_addr  = cpu_addr;
          w_wdata = cpu_wdata;
          w_wr    = cpu_wr;
        end
        if (w_start) w_nextState = S_ACCESS;
      end
      S_ACCESS: begin
        if (w_lastCycle) w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      r_grant    <= G_SCR;
      r_cnt      <= 3'd0;
      r_addr     <= 19'd0;
      r_wdata    <= 8'd0;
      r_wr       <= 1'b0;
      r_scrAck   <= 1'b0;
      r_initAck  <= 1'b0;
      r_cpuAck   <= 1'b0;
      r_scrData  <= 8'd0;
      r_cpuRdata <= 8'd0;
`ifdef VRAM_WRITE_POST_EN
      r_postValid <= 1'b0;
      r_postAddr  <= 19'd0;
      r_postData  <= 8'd0;
`endif
    end else begin
      r_scrAck  <= 1'b0;
      r_initAck <= 1'b0;
      r_cpuAck  <= 1'b0;
      if (w_start) begin
        r_grant <= w_grant;
        r_addr  <= w_addr;
        r_wdata <= w_wdata;
        r_wr    <= w_wr;
        r_cnt   <= 3'd0;
      end else if (r_state == S_ACCESS) begin
        r_cnt <= r_cnt + 3'd1;
      end
      // Read data is sampled at the end of the last access cycle.
      if (w_lastCycle) begin
        case (r_grant)
          G_SCR: begin
            r_scrAck  <= 1'b1;
            r_scrData <= vd_in;
          end
          G_INIT: r_initAck <= 1'b1;
          G_CPU: begin
            r_cpuAck <= 1'b1;
            if (!r_wr) r_cpuRdata <= vd_in;
          end
`ifdef VRAM_WRITE_POST_EN
          G_DRAIN: r_postValid <= 1'b0;
`endif
          default: ;
        endcase
      end
`ifdef VRAM_WRITE_POST_EN
      if (w_post) begin
        r_postValid <= 1'b1;
        r_postAddr  <= cpu_addr;
        r_postData  <= cpu_wdata;
        r_cpuAck    <= 1'b1;
      end
`endif
    end
  end

  // The write strobe skips the first and last access cycles for address setup/hold.
  assign busy      = (r_state == S_ACCESS);
  assign va        = r_addr;
  assign vd_out    = r_wdata;
  assign vd_oe     = busy & r_wr;
  assign n_vrd     = ~(busy & ~r_wr);
  assign n_vwr     = ~(busy & r_wr & (r_cnt != 3'd0) & (r_cnt != LAST_CNT));
  assign scr_ack   = r_scrAck;
  assign init_ack  = r_initAck;
  assign cpu_ack   = r_cpuAck;
  assign scr_data  = r_scrData;
  assign cpu_rdata = r_cpuRdata;

endmodule
